// File: rtl/branch_resolve_if.sv
// ---------------------------------------------------------------------------
// branch_resolve_if
//   Bundles the fetch-side push channel, the EX resolve channel and the
//   predictor update / redirect outputs of branch_resolve.
//
//   Handshake: a push transfers on a rising clk edge where push_valid=1 and
//   push_ready=1; a push with push_ready=0 is dropped, not held. res_valid
//   has no ready: it always refers to the oldest outstanding branch and is
//   consumed on the edge it is sampled. record_we and redirect are
//   single-cycle pulses.
//
//   Modports:
//     master : fetch/EX side (drives push_* and res_*)
//     slave  : branch_resolve (drives push_ready, record_*, redirect*)
//   dbg_state exposes the resolver FSM (0 = NORMAL, 1 = FLUSH).
// ---------------------------------------------------------------------------
interface branch_resolve_if #(
    parameter int PC_W = 32
);
    logic            push_valid;
    logic [PC_W-1:0] push_pc;
    logic            push_taken;
    logic [PC_W-1:0] push_target;
    logic            push_ready;

    logic            res_valid;
    logic            res_taken;
    logic [PC_W-1:0] res_target;

    logic            record_we;
    logic [4:0]      record_pc;
    logic            record_data;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            dbg_state;

    modport master (
        output push_valid, push_pc, push_taken, push_target,
        output res_valid, res_taken, res_target,
        input  push_ready, record_we, record_pc, record_data,
        input  redirect, redirect_pc, dbg_state
    );

    modport slave (
        input  push_valid, push_pc, push_taken, push_target,
        input  res_valid, res_taken, res_target,
        output push_ready, record_we, record_pc, record_data,
        output redirect, redirect_pc, dbg_state
    );
endinterface

// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
//   Keeps an in-order queue of predictions issued at fetch. When EX resolves
//   the oldest branch, the actual outcome is compared with the prediction,
//   the predictor update port is driven and, on a mispredict, fetch is
//   redirected and all younger (wrong-path) entries are flushed.
//
//   Ports:
//     clk, rstn         clock, synchronous active-low reset
//     bus (slave)       push channel, resolve channel, record/redirect outputs
//     branch_cnt        resolved branches, saturating at 16'hFFFF
//     mispred_cnt       mispredictions, saturating at 16'hFFFF
//     err               sticky: resolve seen while queue empty
// ---------------------------------------------------------------------------
module branch_resolve #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    branch_resolve_if.slave   bus,
    output logic [15:0]       branch_cnt,
    output logic [15:0]       mispred_cnt,
    output logic              err
);
    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FLUSH  = 1'b1
    } state_t;

    // Queue storage
    logic [PC_W-1:0]  r_pc_q     [DEPTH];
    logic             r_taken_q  [DEPTH];
    logic [PC_W-1:0]  r_target_q [DEPTH];

    state_t           r_state;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             r_record_we;
    logic [4:0]       r_record_pc;
    logic             r_record_data;
    logic             r_redirect;
    logic [PC_W-1:0]  r_redirect_pc;
    logic [15:0]      r_branch_cnt;
    logic [15:0]      r_mispred_cnt;
    logic             r_err;

    logic [PC_W-1:0]  w_head_pc;
    logic             w_head_taken;
    logic [PC_W-1:0]  w_head_target;
    logic             w_push_ready;
    logic             w_do_res;
    logic             w_mispred;
    logic             w_do_push;
    logic             w_res_empty;

    assign w_head_pc     = r_pc_q[r_rd_ptr];
    assign w_head_taken  = r_taken_q[r_rd_ptr];
    assign w_head_target = r_target_q[r_rd_ptr];

    // Readiness uses the pre-edge count only: a full queue refuses a push
    // even when a same-cycle resolve is freeing a slot.
    assign w_push_ready = (r_count != FULL_CNT) && (r_state == ST_NORMAL);
    assign w_do_res     = bus.res_valid && (r_state == ST_NORMAL) && (r_count != '0);
    assign w_res_empty  = bus.res_valid && (r_state == ST_NORMAL) && (r_count == '0);

    // Target only matters when the branch is actually taken.
    assign w_mispred = w_do_res &&
                       ((bus.res_taken != w_head_taken) ||
                        (bus.res_taken && (bus.res_target != w_head_target)));

    // A push arriving with a mispredict is on the wrong path: discard it.
    assign w_do_push = bus.push_valid && w_push_ready && !w_mispred;

    always_ff @(posedge clk) begin
        if (rstn && w_do_push) begin
            r_pc_q[r_wr_ptr]     <= bus.push_pc;
            r_taken_q[r_wr_ptr]  <= bus.push_taken;
            r_target_q[r_wr_ptr] <= bus.push_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= ST_NORMAL;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_record_we   <= 1'b0;
            r_record_pc   <= '0;
            r_record_data <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
            r_err         <= 1'b0;
        end else begin
            r_record_we <= w_do_res;
            r_redirect  <= w_mispred;

            if (w_do_res) begin
                r_record_pc   <= w_head_pc[6:2];
                r_record_data <= bus.res_taken;
                if (r_branch_cnt != 16'hFFFF) begin
                    r_branch_cnt <= r_branch_cnt + 16'd1;
                end
            end

            if (w_mispred) begin
                r_redirect_pc <= bus.res_taken ? bus.res_target
                                               : w_head_pc + PC_W'(4);
                if (r_mispred_cnt != 16'hFFFF) begin
                    r_mispred_cnt <= r_mispred_cnt + 16'd1;
                end
            end

            if (w_res_empty) begin
                r_err <= 1'b1;
            end

            case (r_state)
                ST_NORMAL: begin
                    if (w_mispred) begin
                        // Drop every entry younger than the mispredicted one.
                        r_state  <= ST_FLUSH;
                        r_rd_ptr <= r_wr_ptr;
                        r_count  <= '0;
                    end else begin
                        if (w_do_push) begin
                            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                        end
                        if (w_do_res) begin
                            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                        end
                        if (w_do_push && !w_do_res) begin
                            r_count <= r_count + (PTR_W+1)'(1);
                        end else if (!w_do_push && w_do_res) begin
                            r_count <= r_count - (PTR_W+1)'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_NORMAL;
                end
                default: begin
                    r_state <= ST_NORMAL;
                end
            endcase
        end
    end

    assign bus.push_ready  = w_push_ready;
    assign bus.record_we   = r_record_we;
    assign bus.record_pc   = r_record_pc;
    assign bus.record_data = r_record_data;
    assign bus.redirect    = r_redirect;
    assign bus.redirect_pc = r_redirect_pc;
    assign bus.dbg_state   = r_state;

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;
    assign err         = r_err;
endmodule

// File: tb/tb_branch_resolve.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve
//   Directed-vector bench for branch_resolve (DEPTH=4, PC_W=32).
// ---------------------------------------------------------------------------
module tb_branch_resolve;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic        clk;
    logic        rstn;
    logic [15:0] branch_cnt;
    logic [15:0] mispred_cnt;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    // Pending queue of bench-side branch ids (k) and their expected record_pc.
    logic [31:0] pend_q[$];
    logic [4:0]  exp_q[$];

    branch_resolve_if #(.PC_W(PC_W)) bus ();

    branch_resolve #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .branch_cnt  (branch_cnt),
        .mispred_cnt (mispred_cnt),
        .err         (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.push_valid  = 1'b0;
        bus.push_pc     = '0;
        bus.push_taken  = 1'b0;
        bus.push_target = '0;
        bus.res_valid   = 1'b0;
        bus.res_taken   = 1'b0;
        bus.res_target  = '0;
    endtask

    task automatic drive_push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        bus.push_valid  = 1'b1;
        bus.push_pc     = pc;
        bus.push_taken  = tk;
        bus.push_target = tgt;
    endtask

    task automatic drive_res(input logic tk, input logic [31:0] tgt);
        bus.res_valid  = 1'b1;
        bus.res_taken  = tk;
        bus.res_target = tgt;
    endtask

    // Branch id k: pc = 0x2000 + 4k, predicted taken = k[0],
    // predicted target = taken ? pc+0x40 : pc+4.
    function automatic logic [31:0] k_pc(input logic [31:0] k);
        return 32'h2000 + (k << 2);
    endfunction

    function automatic logic [31:0] k_tgt(input logic [31:0] k);
        return k[0] ? k_pc(k) + 32'h40 : k_pc(k) + 32'h4;
    endfunction

    function automatic logic [4:0] k_rec(input logic [31:0] k);
        logic [31:0] p;
        p = k_pc(k);
        return p[6:2];
    endfunction

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pushed;
        int mcnt;
        logic [31:0] head;

        idle_inputs();
        rstn = 1'b0;
        tick();
        tick();

        // Reset state
        check_eq("rst_record_we",   32'(bus.record_we),   32'h0);
        check_eq("rst_record_pc",   32'(bus.record_pc),   32'h0);
        check_eq("rst_record_data", 32'(bus.record_data), 32'h0);
        check_eq("rst_redirect",    32'(bus.redirect),    32'h0);
        check_eq("rst_redirect_pc", bus.redirect_pc,      32'h0);
        check_eq("rst_branch_cnt",  32'(branch_cnt),      32'h0);
        check_eq("rst_mispred_cnt", 32'(mispred_cnt),     32'h0);
        check_eq("rst_err",         32'(err),             32'h0);
        check_eq("rst_push_ready",  32'(bus.push_ready),  32'h1);
        rstn = 1'b1;
        tick();

        // Correct prediction
        drive_push(32'h40, 1'b1, 32'h80);
        tick();
        idle_inputs();
        drive_res(1'b1, 32'h80);
        tick();
        idle_inputs();
        check_eq("ok_record_we",   32'(bus.record_we),   32'h1);
        check_eq("ok_record_pc",   32'(bus.record_pc),   32'h10);
        check_eq("ok_record_data", 32'(bus.record_data), 32'h1);
        check_eq("ok_redirect",    32'(bus.redirect),    32'h0);
        check_eq("ok_branch_cnt",  32'(branch_cnt),      32'h1);
        check_eq("ok_mispred_cnt", 32'(mispred_cnt),     32'h0);
        tick();
        check_eq("ok_record_we_pulse", 32'(bus.record_we), 32'h0);

        // Direction mispredict with two younger wrong-path entries
        drive_push(32'h100, 1'b1, 32'h200);
        tick();
        drive_push(32'h108, 1'b0, 32'h10c);
        tick();
        drive_push(32'h110, 1'b1, 32'h400);
        tick();
        idle_inputs();
        drive_res(1'b0, 32'h0);
        drive_push(32'h500, 1'b0, 32'h504);   // same-cycle push, must be discarded
        tick();
        check_eq("dir_redirect",    32'(bus.redirect),    32'h1);
        check_eq("dir_redirect_pc", bus.redirect_pc,      32'h104);
        check_eq("dir_record_we",   32'(bus.record_we),   32'h1);
        check_eq("dir_record_pc",   32'(bus.record_pc),   32'h0);
        check_eq("dir_record_data", 32'(bus.record_data), 32'h0);
        check_eq("dir_mispred_cnt", 32'(mispred_cnt),     32'h1);
        check_eq("dir_branch_cnt",  32'(branch_cnt),      32'h2);
        check_eq("flush_push_ready", 32'(bus.push_ready), 32'h0);
        check_eq("flush_state",     32'(bus.dbg_state),   32'h1);
        // FLUSH cycle: both channels active, both must be ignored
        drive_res(1'b1, 32'h999);
        drive_push(32'h600, 1'b1, 32'h700);
        tick();
        idle_inputs();
        check_eq("post_flush_push_ready", 32'(bus.push_ready), 32'h1);
        check_eq("post_flush_redirect",   32'(bus.redirect),   32'h0);
        check_eq("post_flush_record_we",  32'(bus.record_we),  32'h0);
        check_eq("post_flush_branch_cnt", 32'(branch_cnt),     32'h2);
        check_eq("post_flush_err",        32'(err),            32'h0);
        // Queue must be empty: a resolve now is an error and records nothing
        drive_res(1'b1, 32'h0);
        tick();
        idle_inputs();
        check_eq("empty_err",        32'(err),           32'h1);
        check_eq("empty_record_we",  32'(bus.record_we), 32'h0);
        check_eq("empty_branch_cnt", 32'(branch_cnt),    32'h2);
        tick();
        check_eq("err_sticky", 32'(err), 32'h1);

        // Target mispredict
        drive_push(32'h200, 1'b1, 32'h300);
        tick();
        idle_inputs();
        drive_res(1'b1, 32'h340);
        tick();
        idle_inputs();
        check_eq("tgt_redirect",    32'(bus.redirect),    32'h1);
        check_eq("tgt_redirect_pc", bus.redirect_pc,      32'h340);
        check_eq("tgt_record_data", 32'(bus.record_data), 32'h1);
        check_eq("tgt_mispred_cnt", 32'(mispred_cnt),     32'h2);
        check_eq("tgt_branch_cnt",  32'(branch_cnt),      32'h3);
        tick();
        check_eq("tgt_redirect_pulse", 32'(bus.redirect), 32'h0);

        // Full / wrap: 3*DEPTH branches through the queue
        pushed = 0;
        mcnt   = 0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_push(k_pc(32'(pushed)), k_pc(32'(pushed)) >> 2 & 1, k_tgt(32'(pushed)));
            bus.push_taken = pushed[0];
            tick();
            pend_q.push_back(32'(pushed));
            exp_q.push_back(k_rec(32'(pushed)));
            pushed++;
            mcnt++;
        end
        idle_inputs();
        check_eq("full_push_ready", 32'(bus.push_ready), 32'h0);
        drive_push(k_pc(32'd20), 1'b0, k_pc(32'd20) + 32'h4);   // dropped
        tick();
        idle_inputs();
        for (int cyc = 0; cyc < 40 && !(pushed == 3*DEPTH && mcnt == 0); cyc++) begin
            logic do_res;
            logic do_push;
            logic [31:0] k;
            do_res  = (mcnt > 0);
            do_push = (pushed < 3*DEPTH) && (mcnt < DEPTH);
            idle_inputs();
            if (do_push) begin
                k = 32'(pushed);
                drive_push(k_pc(k), k[0], k_tgt(k));
            end
            if (do_res) begin
                head = pend_q[0];
                // Not-taken resolutions carry a junk target that must be ignored.
                drive_res(head[0], head[0] ? k_tgt(head) : 32'hDEAD_BEEF);
            end
            tick();
            if (do_res) begin
                void'(pend_q.pop_front());
                check_eq("wrap_record_we", 32'(bus.record_we), 32'h1);
                check_eq("wrap_record_pc", 32'(bus.record_pc), 32'(exp_q.pop_front()));
                check_eq("wrap_redirect",  32'(bus.redirect),  32'h0);
                mcnt--;
            end
            if (do_push) begin
                pend_q.push_back(32'(pushed));
                exp_q.push_back(k_rec(32'(pushed)));
                pushed++;
                mcnt++;
            end
            check_eq("wrap_push_ready", 32'(bus.push_ready), 32'(mcnt != DEPTH));
        end
        idle_inputs();
        check_eq("wrap_done", 32'(pushed == 3*DEPTH && mcnt == 0), 32'h1);
        check_eq("wrap_branch_cnt",  32'(branch_cnt),  32'(3 + 3*DEPTH));
        check_eq("wrap_mispred_cnt", 32'(mispred_cnt), 32'h2);

        // Saturation: one entry in flight, push+correct resolve every cycle
        drive_push(32'h3000, 1'b0, 32'h3004);
        tick();
        drive_res(1'b0, 32'h0);
        repeat (65540) tick();
        idle_inputs();
        drive_res(1'b0, 32'h0);
        tick();
        idle_inputs();
        check_eq("sat_branch_cnt",  32'(branch_cnt),  32'hFFFF);
        check_eq("sat_mispred_cnt", 32'(mispred_cnt), 32'h2);
        check_eq("sat_push_ready",  32'(bus.push_ready), 32'h1);

        // Reset mid-operation discards queued entries and clears state
        drive_push(32'h4000, 1'b1, 32'h4100);
        tick();
        drive_push(32'h4004, 1'b0, 32'h4008);
        tick();
        idle_inputs();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check_eq("mid_rst_branch_cnt", 32'(branch_cnt), 32'h0);
        check_eq("mid_rst_err",        32'(err),        32'h0);
        drive_res(1'b1, 32'h4100);
        tick();
        idle_inputs();
        check_eq("mid_rst_empty_err", 32'(err),           32'h1);
        check_eq("mid_rst_record_we", 32'(bus.record_we), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Resolution-side companion to the pattern-history branch predictor.
- Holds a small in-order queue of predictions issued at fetch. When EX resolves each branch, it compares the actual outcome with the prediction and drives the predictor update port (record_we/record_pc/record_data).
- On a misprediction it raises a redirect and flushes wrong-path entries.
- Sits between the IF predictor lookup and the EX branch unit.

Parameters:
DEPTH, 4, number of in-flight predicted branches held (power of 2, ≥2)
PC_W, 32, PC width

Ports:
clk  input  1  clock; all state updates on posedge
rstn  input  1  synchronous active-low reset, sampled on posedge clk
push_valid  input  1  IF issues a predicted branch this cycle
push_pc  input  PC_W  PC of that branch
push_taken  input  1  predicted direction (predictor output)
push_target  input  PC_W  predicted next PC (target if taken, pc+4 if not)
push_ready  output  1  queue accepts a push (not full and state NORMAL)
res_valid  input  1  EX resolves the oldest outstanding branch
res_taken  input  1  actual direction
res_target  input  PC_W  actual taken target (ignored when res_taken=0)
record_we  output  1  predictor update strobe
record_pc  output  5  pc[6:2] of resolved branch
record_data  output  1  actual direction
redirect  output  1  mispredict pulse to fetch/flush logic
redirect_pc  output  PC_W  correct next PC
branch_cnt  output  16  resolved branches, saturating
mispred_cnt  output  16  mispredictions, saturating
err  output  1  sticky: resolve with empty queue

Behaviour:
- Reset (rstn=0 at posedge):
  - Pointers and count cleared; state NORMAL.
  - record_we=0, record_pc=0, record_data=0, redirect=0, redirect_pc=0.
  - Counters 0; err=0.
  - Reset mid-operation discards all entries.
- Queue: circular FIFO of {pc, taken, target}.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
  - push_ready = (count != DEPTH) && state==NORMAL.
  - A push with push_ready=0 is dropped silently.
- Resolve (res_valid=1, state NORMAL, count>0): pop the head entry.
  - mispredict = (res_taken != taken) || (res_taken && res_target != target).
- Outputs are registered; latency is 1 cycle from the sampling edge.
  - The cycle after a resolve: record_we=1, record_pc=head.pc[6:2], record_data=res_taken.
  - record_we is asserted for every resolve, correct or not.
  - redirect=1 only on mispredict; redirect_pc = res_taken ? res_target : head.pc+4 (modulo 2^PC_W).
  - record_we and redirect are single-cycle pulses and return to 0 the next cycle unless a new resolve occurs.
- Counters:
  - branch_cnt increments on every resolve; mispred_cnt increments on every mispredict.
  - Both hold at 16'hFFFF (no wrap).
- FSM:
  - NORMAL → FLUSH on mispredict. At that edge the queue is emptied (count=0, rd_ptr=wr_ptr), and a same-cycle push is discarded.
  - FLUSH: lasts exactly 1 cycle. push_ready=0; push_valid and res_valid are ignored, with no counter changes. Then FLUSH → NORMAL.
- Simultaneous push and correct resolve in NORMAL: both take effect; count is unchanged.
  - A push is accepted when full if a same-cycle correct resolve frees a slot? No: push_ready is based on the pre-edge count only.
- Resolve with count==0 in NORMAL: no pop, no record_we, no counter change; err set (sticky until reset).

Test Plan:
- Reset then idle: after rstn=0 for 2 cycles, all outputs 0, push_ready=1, branch_cnt=0.
- Correct prediction:
  - Push pc=0x0000_0040, taken=1, target=0x0000_0080.
  - Next cycle resolve taken=1, target=0x80.
  - One cycle later: record_we=1, record_pc=5'h10, record_data=1, redirect=0, branch_cnt=1, mispred_cnt=0.
- Direction mispredict:
  - Push pc=0x0000_0100, taken=1, target=0x200; push two more branches.
  - Resolve with taken=0.
  - Next cycle: redirect=1, redirect_pc=0x0000_0104, record_data=0, mispred_cnt=1.
  - Queue empty; push_ready=0 for 1 cycle, then 1.
  - A later res_valid with empty queue sets err=1.
- Target mispredict: predicted target=0x300, actual taken target=0x340 → redirect=1, redirect_pc=0x340.
- Full/wrap:
  - Push DEPTH entries → push_ready=0; an extra push is dropped.
  - Resolve all entries in order, interleaving push+resolve for 3×DEPTH branches.
  - record_pc sequence matches push order across pointer wrap.
- Saturation: force 65536+ correct resolves → branch_cnt holds at 16'hFFFF.
